// File: rtl/fifo_umbral.sv
// Synchronous FIFO with live almost-full/almost-empty thresholds and a sticky
// error flag that records any rejected write (full) or rejected read (empty).
module fifo_umbral #(
  parameter int MEM_SIZE  = 8,
  parameter int WORD_SIZE = 10,
  parameter int PTR       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_wr,
  input  logic                 fifo_rd,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic [PTR-1:0]       full_threshold,
  input  logic [PTR-1:0]       empty_threshold,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error
);

  localparam logic [PTR:0] MEM_CNT = (PTR+1)'(MEM_SIZE);

  logic [WORD_SIZE-1:0] mem [MEM_SIZE];
  logic [PTR-1:0]       wr_ptr;
  logic [PTR-1:0]       rd_ptr;
  logic [PTR:0]         count;
  logic                 wr_ok;
  logic                 rd_ok;

  // A write into a full FIFO is only allowed when a read frees the slot on the same edge.
  assign rd_ok = fifo_rd && (count != '0);
  assign wr_ok = fifo_wr && ((count < MEM_CNT) || (fifo_rd && (count == MEM_CNT)));

  assign fifo_full    = (count == MEM_CNT);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= {1'b0, full_threshold}) && !fifo_full;
  assign almost_empty = (count <= {1'b0, empty_threshold}) && !fifo_empty;

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= fifo_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_data_out <= '0;
      error         <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        fifo_data_out <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      if ((fifo_wr && !wr_ok) || (fifo_rd && !rd_ok)) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_umbral.sv
// Scoreboard bench for fifo_umbral: a queue holds the words the bench expects
// to read back, plus a small occupancy/error model for the status flags.
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_wr;
  logic       fifo_rd;
  logic [9:0] fifo_data_in;
  logic [2:0] full_threshold;
  logic [2:0] empty_threshold;
  logic [9:0] fifo_data_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;

  int checks = 0;
  int errors = 0;

  logic [9:0] sb[$];
  int         m_count;
  logic       m_err;
  logic [9:0] m_dout;
  logic [4:0] flags;

  always #5 clk = ~clk;

  assign flags = {fifo_full, fifo_empty, almost_full, almost_empty, error};

  fifo_umbral #(.MEM_SIZE(8), .WORD_SIZE(10), .PTR(3)) dut (
    .clk(clk),
    .reset(reset),
    .fifo_wr(fifo_wr),
    .fifo_rd(fifo_rd),
    .fifo_data_in(fifo_data_in),
    .full_threshold(full_threshold),
    .empty_threshold(empty_threshold),
    .fifo_data_out(fifo_data_out),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .error(error)
  );

  function automatic logic [4:0] exp_flags();
    logic f, e, af, ae;
    f  = (m_count == 8);
    e  = (m_count == 0);
    af = (m_count >= int'(full_threshold)) && !f;
    ae = (m_count <= int'(empty_threshold)) && !e;
    return {f, e, af, ae, m_err};
  endfunction

  // Drive one cycle of stimulus and advance the reference model alongside it.
  task automatic step(input logic wr, input logic rd, input logic [9:0] d);
    bit wr_acc, rd_acc;
    @(negedge clk);
    fifo_wr      = wr;
    fifo_rd      = rd;
    fifo_data_in = d;
    wr_acc = wr && (m_count < 8 || (rd && m_count == 8));
    rd_acc = rd && (m_count > 0);
    if (rd_acc) m_dout = sb.pop_front();
    if (wr_acc) sb.push_back(d);
    if (wr_acc && !rd_acc) m_count++;
    if (rd_acc && !wr_acc) m_count--;
    if ((wr && !wr_acc) || (rd && !rd_acc)) m_err = 1'b1;
    @(posedge clk);
    #1;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_err   = 1'b0;
    m_dout  = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (flags !== 5'b01000 || fifo_data_out !== 10'h000) begin
      errors++;
      $display("FAIL reset_state flags=%b dout=%h want flags=01000 dout=000", flags, fifo_data_out);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 10'(k));
      checks++;
      if (flags !== exp_flags()) begin
        errors++;
        $display("FAIL fill_flags k=%0d got %b want %b", k, flags, exp_flags());
      end
      checks++;
      if (almost_empty !== (k <= 2) || almost_full !== (k == 6 || k == 7) || fifo_full !== (k == 8)) begin
        errors++;
        $display("FAIL fill_levels k=%0d ae=%b af=%b full=%b", k, almost_empty, almost_full, fifo_full);
      end
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 10'h3FF);
    checks++;
    if (flags !== exp_flags() || error !== 1'b1 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow got %b want %b", flags, exp_flags());
    end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 10'h000);
      checks++;
      if (fifo_data_out !== m_dout || fifo_data_out !== 10'(k)) begin
        errors++;
        $display("FAIL drain_data k=%0d got %h want %h", k, fifo_data_out, m_dout);
      end
      checks++;
      if (flags !== exp_flags()) begin
        errors++;
        $display("FAIL drain_flags k=%0d got %b want %b", k, flags, exp_flags());
      end
    end
    step(1'b0, 1'b1, 10'h000);
    checks++;
    if (error !== 1'b1 || fifo_empty !== 1'b1 || fifo_data_out !== 10'h008) begin
      errors++;
      $display("FAIL underflow err=%b empty=%b dout=%h want 1 1 008", error, fifo_empty, fifo_data_out);
    end
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 10'h040 + 10'(k));
    step(1'b1, 1'b1, 10'h2AA);
    checks++;
    if (fifo_data_out !== m_dout || fifo_data_out !== 10'h040 || flags !== exp_flags() || error !== 1'b0) begin
      errors++;
      $display("FAIL simul_full dout=%h flags=%b want dout=%h flags=%b", fifo_data_out, flags, m_dout, exp_flags());
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 10'h000);
      checks++;
      if (fifo_data_out !== m_dout) begin
        errors++;
        $display("FAIL simul_drain k=%0d got %h want %h", k, fifo_data_out, m_dout);
      end
    end
    step(1'b1, 1'b1, 10'h155);
    checks++;
    if (flags !== exp_flags() || flags !== 5'b00011) begin
      errors++;
      $display("FAIL simul_empty got %b want %b", flags, exp_flags());
    end
    step(1'b0, 1'b1, 10'h000);
    checks++;
    if (fifo_data_out !== 10'h155 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_readback got %h want 155", fifo_data_out);
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 10'h100 + 10'(k));
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 10'($urandom_range(0, 1023)));
      checks++;
      if (fifo_data_out !== m_dout || flags !== exp_flags() || m_count != 3) begin
        errors++;
        $display("FAIL wrap k=%0d dout=%h want %h flags=%b want %b", k, fifo_data_out, m_dout, flags, exp_flags());
      end
    end
    // Thresholds are live: raising the empty threshold flips the flag without a clock edge.
    @(negedge clk);
    empty_threshold = 3'd3;
    #1;
    checks++;
    if (almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL live_threshold almost_empty=%b want 1", almost_empty);
    end
    empty_threshold = 3'd2;
  endtask

  task automatic test_async_reset();
    pulse_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 10'h200 + 10'(k));
    step(1'b0, 1'b1, 10'h000);
    checks++;
    if (fifo_data_out !== 10'h200 || flags !== exp_flags()) begin
      errors++;
      $display("FAIL pre_reset dout=%h flags=%b want 200 %b", fifo_data_out, flags, exp_flags());
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (flags !== 5'b01000 || fifo_data_out !== 10'h000) begin
      errors++;
      $display("FAIL async_reset flags=%b dout=%h want 01000 000", flags, fifo_data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 10'h0AB);
    step(1'b0, 1'b1, 10'h000);
    checks++;
    if (fifo_data_out !== 10'h0AB || flags !== exp_flags()) begin
      errors++;
      $display("FAIL post_reset dout=%h flags=%b want 0ab %b", fifo_data_out, flags, exp_flags());
    end
  endtask

  initial begin
    reset           = 1'b0;
    fifo_wr         = 1'b0;
    fifo_rd         = 1'b0;
    fifo_data_in    = '0;
    full_threshold  = 3'd6;
    empty_threshold = 3'd2;
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_umbral.md
FIFO_UMBRAL -- requirements
Module: fifo_umbral

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 8: FIFO depth in words.
REQ-002 SHALL have parameter WORD_SIZE, default 10: data width in bits.
REQ-003 SHALL have parameter PTR, default 3: pointer width, with 2**PTR == MEM_SIZE.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port fifo_wr, input, 1 bit: write request.
REQ-007 SHALL have port fifo_rd, input, 1 bit: read request.
REQ-008 SHALL have port fifo_data_in, input, WORD_SIZE bits: write data.
REQ-009 SHALL have port full_threshold, input, PTR bits: almost-full level.
REQ-010 SHALL have port empty_threshold, input, PTR bits: almost-empty level.
REQ-011 SHALL have port fifo_data_out, output, WORD_SIZE bits: registered read data.
REQ-012 SHALL have port fifo_full, output, 1 bit: occupancy == MEM_SIZE.
REQ-013 SHALL have port fifo_empty, output, 1 bit: occupancy == 0.
REQ-014 SHALL have port almost_full, output, 1 bit: threshold flag.
REQ-015 SHALL have port almost_empty, output, 1 bit: threshold flag.
REQ-016 SHALL have port error, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-017 SHALL hold MEM_SIZE x WORD_SIZE storage, write pointer wr_ptr (PTR bits), read pointer rd_ptr (PTR bits) and occupancy count (PTR+1 bits, range 0..MEM_SIZE).
REQ-018 SHALL accept a write when fifo_wr=1 and (count<MEM_SIZE, or fifo_rd=1 with count==MEM_SIZE).
REQ-019 On an accepted write, SHALL store fifo_data_in at mem[wr_ptr] and increment wr_ptr modulo MEM_SIZE (natural wrap 7->0).
REQ-020 SHALL accept a read when fifo_rd=1 and count>0.
REQ-021 On an accepted read, SHALL load fifo_data_out <= mem[rd_ptr] on that edge (1-cycle latency) and increment rd_ptr modulo MEM_SIZE.
REQ-022 fifo_data_out SHALL hold its value on all cycles without an accepted read.
REQ-023 Count SHALL update +1 for write-only, -1 for read-only, and stay unchanged for accepted read+write or for no accepted operation.
REQ-024 Simultaneous rd+wr when empty: write accepted, read rejected, count becomes 1, error set.
REQ-025 Simultaneous rd+wr when full: both accepted, count stays MEM_SIZE, oldest word output, error not set.
REQ-026 Rejected operations SHALL NOT move pointers or modify memory.
REQ-027 fifo_full = (count==MEM_SIZE) and fifo_empty = (count==0), both decoded from the registered count.
REQ-028 almost_full = (count >= full_threshold) && !fifo_full, decoded from the registered count.
REQ-029 almost_empty = (count <= empty_threshold) && !fifo_empty, decoded from the registered count.
REQ-030 Thresholds SHALL be used live and not latched; a threshold change affects the flags in the same cycle.
REQ-031 error SHALL be set on the edge where a write is rejected (fifo_wr=1, full, no rd) or a read is rejected (fifo_rd=1, empty).
REQ-032 Once set, error SHALL remain 1 until reset.

Reset
REQ-033 While reset=0, asynchronously: wr_ptr=0, rd_ptr=0, count=0, fifo_data_out=0, error=0.
REQ-034 During and after reset the outputs SHALL be fifo_empty=1, fifo_full=0, almost_full=0, almost_empty=0.
REQ-035 Reset SHALL NOT be required to clear memory contents.
REQ-036 Reset asserted mid-burst SHALL abort all operations; the first edge after release behaves as from empty.

Verification
REQ-037 Fill: thresholds full=6/empty=2; write 0x001..0x008 on consecutive cycles. Required: almost_empty=1 at count 1..2; almost_full=1 at count 6..7; fifo_full=1 at count 8 with almost_full=0; error=0.
REQ-038 Overflow: at full, write 0x3FF with rd=0. Required: error=1 next edge; count stays 8; later reads return 0x001..0x008 with no 0x3FF.
REQ-039 Drain/underflow: read 8 times, then read once more. Required: data_out 0x001..0x008, each 1 cycle after its read; fifo_empty=1; extra read sets error=1 and data_out stays 0x008.
REQ-040 Simultaneous: full, rd=wr=1 with data 0x2AA. Required: data_out=oldest, count=8, error=0. Empty, rd=wr=1 with 0x155: count=1, error=1, next read returns 0x155.
REQ-041 Wrap-around: 20 interleaved write/read pairs at count 3. Required: FIFO order preserved across pointer wrap; count constant at 3.
REQ-042 Async reset: drop reset mid-clock-period with count=5. Required: outputs take reset values immediately, without waiting for a clk edge; after release a write then read returns the new word.
